// File: rtl/booth_mac_acc_if.sv
// booth_mac_acc_if
//   Bundles the product stream and the result stream of the Booth MAC
//   accumulator.
//   Handshake rule for both streams: a transfer happens on a rising clk edge
//   where valid and ready are both 1. Valid, once raised, is not withdrawn by
//   the block. The payload fields are only meaningful while valid is 1.
//   Signals:
//     prod_valid/prod_ready/prod_data[15:0]/prod_last : product input stream
//     acc_valid/acc_ready/acc_data[ACC_W-1:0]/acc_count[8:0]/acc_ovf : result stream
//   Modports:
//     slave  : the accumulator (consumes products, produces results)
//     master : the environment (produces products, consumes results)
interface booth_mac_acc_if #(
    parameter int ACC_W = 24
);
    logic             prod_valid;
    logic             prod_ready;
    logic [15:0]      prod_data;
    logic             prod_last;
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] acc_data;
    logic [8:0]       acc_count;
    logic             acc_ovf;

    modport slave (
        input  prod_valid, prod_data, prod_last, acc_ready,
        output prod_ready, acc_valid, acc_data, acc_count, acc_ovf
    );

    modport master (
        output prod_valid, prod_data, prod_last, acc_ready,
        input  prod_ready, acc_valid, acc_data, acc_count, acc_ovf
    );
endinterface

// File: rtl/booth_mac_acc.sv
// booth_mac_acc
//   Streaming accumulation stage behind the 8x8 Booth multiplier. Signed
//   16-bit products are summed into a per-step saturating ACC_W-bit
//   accumulator. A burst closes on prod_last or when MAX_LEN products have
//   been taken; the registered sum, product count and sticky overflow flag
//   are then held on the result stream until the consumer takes them.
//   Ports:
//     clk       : rising-edge clock
//     rst       : synchronous active-high reset
//     bus       : booth_mac_acc_if.slave (product in, result out)
//     dbg_state : current FSM state (0 = ACC, 1 = OUT)
module booth_mac_acc #(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_mac_acc_if.slave        bus,
    output logic                  dbg_state
);
    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    localparam logic [8:0] MAX_CNT = 9'(MAX_LEN);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [8:0]       count;
    logic             ovf;
    logic [ACC_W-1:0] res_data;
    logic [8:0]       res_count;
    logic             res_ovf;

    logic             prod_hs;
    logic             acc_hs;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum;
    logic             sat_hi;
    logic             sat_lo;
    logic [ACC_W-1:0] acc_upd;
    logic             ovf_upd;
    logic [8:0]       count_inc;
    logic             burst_end;

    // Sum is one bit wider than the accumulator so the true result of the
    // step is available; the top two bits disagreeing means it left range.
    always_comb begin
        prod_ext  = {{(ACC_W-16){bus.prod_data[15]}}, bus.prod_data};
        sum       = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
        sat_hi    = ~sum[ACC_W] &  sum[ACC_W-1];
        sat_lo    =  sum[ACC_W] & ~sum[ACC_W-1];
        if (sat_hi) begin
            acc_upd = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (sat_lo) begin
            acc_upd = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_upd = sum[ACC_W-1:0];
        end
        ovf_upd   = ovf | sat_hi | sat_lo;
        count_inc = count + 9'd1;
    end

    // Next state and stream control.
    always_comb begin
        state_nxt      = state;
        bus.prod_ready = 1'b0;
        bus.acc_valid  = 1'b0;
        prod_hs        = 1'b0;
        acc_hs         = 1'b0;
        burst_end      = 1'b0;
        case (state)
            S_ACC: begin
                bus.prod_ready = 1'b1;
                prod_hs        = bus.prod_valid;
                burst_end      = prod_hs & (bus.prod_last | (count_inc == MAX_CNT));
                if (burst_end) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                bus.acc_valid = 1'b1;
                acc_hs        = bus.acc_ready;
                if (acc_hs) begin
                    state_nxt = S_ACC;
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_ACC;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (prod_hs) begin
                acc   <= acc_upd;
                count <= count_inc;
                ovf   <= ovf_upd;
            end
            if (burst_end) begin
                res_data  <= acc_upd;
                res_count <= count_inc;
                res_ovf   <= ovf_upd;
            end
            // Result fields keep their values after consumption; only the
            // running accumulator is cleared for the next burst.
            if (acc_hs) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end
        end
    end

    assign bus.acc_data  = res_data;
    assign bus.acc_count = res_count;
    assign bus.acc_ovf   = res_ovf;
    assign dbg_state     = state;
endmodule

// File: tb/tb_booth_mac_acc.sv
module tb_booth_mac_acc;
    logic        clk;
    logic        rst;
    logic        prod_valid;
    logic [15:0] prod_data;
    logic        prod_last;
    logic        acc_ready;
    logic        dbg24;
    logic        dbg17;

    int n_cmp;
    int n_bad;

    // Expected result word: {ovf, count[8:0], data sign-extended to 32 bits}
    logic [41:0] exp_q24[$];
    logic [41:0] exp_q17[$];

    // Reference model state
    longint m_acc24;
    longint m_acc17;
    bit     m_ovf24;
    bit     m_ovf17;
    int     m_cnt;

    booth_mac_acc_if #(.ACC_W(24)) if24();
    booth_mac_acc_if #(.ACC_W(17)) if17();

    assign if24.prod_valid = prod_valid;
    assign if24.prod_data  = prod_data;
    assign if24.prod_last  = prod_last;
    assign if24.acc_ready  = acc_ready;
    assign if17.prod_valid = prod_valid;
    assign if17.prod_data  = prod_data;
    assign if17.prod_last  = prod_last;
    assign if17.acc_ready  = acc_ready;

    booth_mac_acc #(.ACC_W(24), .MAX_LEN(256)) dut24 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if24.slave),
        .dbg_state (dbg24)
    );

    booth_mac_acc #(.ACC_W(17), .MAX_LEN(256)) dut17 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if17.slave),
        .dbg_state (dbg17)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic longint sat_add(input longint a, input longint p, input int w, output bit o);
        longint s;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        s  = a + p;
        o  = 1'b0;
        if (s > hi) begin
            s = hi;
            o = 1'b1;
        end else if (s < lo) begin
            s = lo;
            o = 1'b1;
        end
        return s;
    endfunction

    task automatic model_clear();
        m_acc24 = 0;
        m_acc17 = 0;
        m_ovf24 = 1'b0;
        m_ovf17 = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic [15:0] d, input logic last);
        longint p;
        bit     o;
        logic [31:0] d24;
        logic [31:0] d17;
        p = longint'($signed(d));
        m_acc24 = sat_add(m_acc24, p, 24, o);
        m_ovf24 = m_ovf24 | o;
        m_acc17 = sat_add(m_acc17, p, 17, o);
        m_ovf17 = m_ovf17 | o;
        m_cnt++;
        if (last || m_cnt == 256) begin
            d24 = 32'(m_acc24);
            d17 = 32'(m_acc17);
            exp_q24.push_back({m_ovf24, 9'(m_cnt), d24});
            exp_q17.push_back({m_ovf17, 9'(m_cnt), d17});
            model_clear();
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [15:0] d, input logic last);
        int waitc;
        waitc      = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
        while (if24.prod_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: prod_ready=%b after %0d cycles, required 1", if24.prod_ready, waitc);
            prod_valid = 1'b0;
            return;
        end
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        model_step(d, last);
    endtask

    // Waits for a result, compares it to the scoreboard, then consumes it.
    task automatic expect_result(input string name);
        int          waitc;
        logic [41:0] e24;
        logic [41:0] e17;
        waitc = 0;
        while (if24.acc_valid !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        n_cmp++;
        if (waitc >= 50) begin
            n_bad++;
            $display("FAIL %s_valid_timeout: acc_valid=%b, required 1", name, if24.acc_valid);
            return;
        end
        if (exp_q24.size() == 0 || exp_q17.size() == 0) begin
            n_bad++;
            $display("FAIL %s_queue: result seen with data=%0d but nothing expected", name, $signed(if24.acc_data));
            return;
        end
        e24 = exp_q24.pop_front();
        e17 = exp_q17.pop_front();
        if (if24.acc_data !== e24[23:0]) begin
            n_bad++;
            $display("FAIL %s_data24: got %0d required %0d", name, $signed(if24.acc_data), $signed(e24[23:0]));
        end
        n_cmp++;
        if (if24.acc_count !== e24[40:32]) begin
            n_bad++;
            $display("FAIL %s_count24: got %0d required %0d", name, if24.acc_count, e24[40:32]);
        end
        n_cmp++;
        if (if24.acc_ovf !== e24[41]) begin
            n_bad++;
            $display("FAIL %s_ovf24: got %b required %b", name, if24.acc_ovf, e24[41]);
        end
        n_cmp++;
        if (if17.acc_data !== e17[16:0]) begin
            n_bad++;
            $display("FAIL %s_data17: got %0d required %0d", name, $signed(if17.acc_data), $signed(e17[16:0]));
        end
        n_cmp++;
        if (if17.acc_count !== e17[40:32]) begin
            n_bad++;
            $display("FAIL %s_count17: got %0d required %0d", name, if17.acc_count, e17[40:32]);
        end
        n_cmp++;
        if (if17.acc_ovf !== e17[41]) begin
            n_bad++;
            $display("FAIL %s_ovf17: got %b required %b", name, if17.acc_ovf, e17[41]);
        end
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        exp_q24.delete();
        exp_q17.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({if24.acc_valid, if24.prod_ready, dbg24} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_ctrl24: valid/ready/state=%b required 010", {if24.acc_valid, if24.prod_ready, dbg24});
        end
        n_cmp++;
        if (if24.acc_data !== 24'd0 || if24.acc_count !== 9'd0 || if24.acc_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fields24: data=%h count=%0d ovf=%b required 0/0/0", if24.acc_data, if24.acc_count, if24.acc_ovf);
        end
        n_cmp++;
        if ({if17.acc_valid, if17.prod_ready, dbg17} !== 3'b010 || if17.acc_data !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_17: valid/ready/state=%b data=%h required 010/0", {if17.acc_valid, if17.prod_ready, dbg17}, if17.acc_data);
        end
    endtask

    task automatic test_basic();
        send(16'd100, 1'b0);
        send(-16'sd50, 1'b0);
        send(16'd7, 1'b1);
        n_cmp++;
        if (if24.acc_valid !== 1'b1 || if24.prod_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_latency: valid=%b ready=%b required 1/0", if24.acc_valid, if24.prod_ready);
        end
        expect_result("basic");
        n_cmp++;
        if (if24.prod_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_ready_back: prod_ready=%b required 1", if24.prod_ready);
        end
    endtask

    task automatic test_gaps();
        repeat (4) @(negedge clk);
        send(16'hFF01, 1'b1);
        expect_result("single_neg");
        send(16'd10, 1'b0);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        send(16'd20, 1'b0);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        send(16'($urandom_range(0, 65535)), 1'b1);
        expect_result("gap_burst");
    endtask

    task automatic test_saturation();
        send(16'd32767, 1'b0);
        send(16'd32767, 1'b0);
        send(16'd32767, 1'b0);
        send(16'hFFFF, 1'b1);
        expect_result("sat_pos");
        send(16'h8000, 1'b0);
        send(16'h8000, 1'b0);
        send(16'h8000, 1'b1);
        expect_result("sat_neg");
    endtask

    task automatic test_backpressure();
        logic [41:0] e24;
        send(16'd11, 1'b0);
        send(16'd22, 1'b1);
        e24        = exp_q24[0];
        prod_valid = 1'b1;
        prod_data  = 16'd999;
        prod_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (if24.prod_ready !== 1'b0 || if24.acc_valid !== 1'b1 || dbg24 !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_ctrl[%0d]: ready=%b valid=%b state=%b required 0/1/1", i, if24.prod_ready, if24.acc_valid, dbg24);
            end
            n_cmp++;
            if (if24.acc_data !== e24[23:0] || if24.acc_count !== e24[40:32]) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: data=%0d count=%0d required %0d/%0d", i, $signed(if24.acc_data), if24.acc_count, $signed(e24[23:0]), e24[40:32]);
            end
            @(negedge clk);
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        expect_result("bp_result");
        send(16'd4, 1'b1);
        expect_result("bp_fresh");
    endtask

    task automatic test_auto_terminate();
        for (int i = 0; i < 256; i++) begin
            send(16'd1, 1'b0);
        end
        expect_result("auto_term");
        send(16'd3, 1'b1);
        expect_result("after_auto");
    endtask

    task automatic test_reset_mid();
        send(16'd9, 1'b0);
        send(16'd9, 1'b0);
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (if24.acc_valid !== 1'b0 || if24.prod_ready !== 1'b1 || if24.acc_data !== 24'd0 || if24.acc_count !== 9'd0) begin
                n_bad++;
                $display("FAIL rst_burst[%0d]: valid=%b ready=%b data=%0d count=%0d required 0/1/0/0", i, if24.acc_valid, if24.prod_ready, $signed(if24.acc_data), if24.acc_count);
            end
            @(negedge clk);
        end
        send(16'd5, 1'b0);
        send(16'd5, 1'b1);
        expect_result("rst_burst_next");
        send(16'd7, 1'b1);
        pulse_reset();
        n_cmp++;
        if (if24.acc_valid !== 1'b0 || if24.acc_data !== 24'd0 || dbg24 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_out: valid=%b data=%0d state=%b required 0/0/0", if24.acc_valid, $signed(if24.acc_data), dbg24);
        end
        send(16'hFFFE, 1'b1);
        expect_result("rst_out_next");
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        prod_valid = 1'b0;
        prod_data  = '0;
        prod_last  = 1'b0;
        acc_ready  = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps();
        test_saturation();
        test_backpressure();
        test_auto_terminate();
        test_reset_mid();
        n_cmp++;
        if (exp_q24.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d expected results never produced, required 0", exp_q24.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
